// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write and synchronous (registered) read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[index] <= wdata;
        end
        rdata <= mem_q[index];
    end

endmodule

// File: rtl/dmem_responder.sv
// Latency-modelling responder for the CPU data-memory port: one request at a time,
// single-cycle ack pulse carrying load data or an error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 128,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int unsigned      IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;

    logic                sel_we;
    logic [WORD_W-1:0]   sel_addr;
    logic [WORD_W-1:0]   sel_wdata;
    logic                sel_err;
    logic                enter_resp;
    logic                arr_we;
    logic [WORD_W-1:0]   arr_rdata;

    // With zero latency the access happens on the acceptance edge, so the live inputs are used.
    always_comb begin
        sel_we    = we_q;
        sel_addr  = addr_q;
        sel_wdata = wdata_q;
        if (state_q == IDLE) begin
            sel_we    = we_i;
            sel_addr  = addr_i;
            sel_wdata = wdata_i;
        end
        sel_err = (sel_addr[1:0] != 2'b00) ||
                  ({2'b00, sel_addr[WORD_W-1:2]} >= WORD_W'(DEPTH_WORDS));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        enter_resp = (state_d == RESP) && (state_q != RESP);
        arr_we     = enter_resp && sel_we && !sel_err && !rst_i;
        err_d      = enter_resp ? sel_err : err_q;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .we    (arr_we),
        .index (sel_addr[IDX_W+1:2]),
        .wdata (sel_wdata),
        .rdata (arr_rdata)
    );

    // Array read is registered on the RESP entry edge; rdata_q retains it once RESP ends.
    always_comb begin
        rdata_o = rdata_q;
        if (state_q == RESP) begin
            if (err_q) begin
                rdata_o = '0;
            end else if (!we_q) begin
                rdata_o = arr_rdata;
            end
        end
        rdata_d = (state_q == RESP) ? rdata_o : rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign ack_o   = (state_q == RESP);
    assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: lane 0 runs LATENCY=2, lane 1 runs LATENCY=0, against a cycle-level reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 128;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } txn_t;

    int          lat [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        ack   [2];
    logic        err   [2];
    logic [31:0] rdata [2];

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          free_at [2];
    logic [31:0] last_rd [2];
    logic        last_err [2];
    logic        prev_ack [2];
    logic [31:0] mem_m [2][DEPTH];
    txn_t        sbq [2][$];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_lat0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    always #5 clk = ~clk;

    function automatic bit is_err(logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic chk(string name, int l, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s lane%0d cyc=%0d: got %h expected %h", name, l, cyc, act, exp);
        end
    endtask

    // Model: accept on an edge when the request is up and the lane was idle in the previous cycle.
    always @(posedge clk) begin
        txn_t t;
        cyc++;
        for (int l = 0; l < 2; l++) begin
            if (!rst && req[l] && (cyc - 1 >= free_at[l])) begin
                t.we    = we[l];
                t.addr  = addr[l];
                t.wdata = wdata[l];
                t.due   = cyc + lat[l];
                sbq[l].push_back(t);
                free_at[l] = cyc + lat[l] + 1;
            end
        end
    end

    // Monitor: compares every cycle; writes are committed to the model when their ack appears.
    always @(negedge clk) begin
        txn_t        t;
        logic [31:0] exp_rd;
        for (int l = 0; l < 2; l++) begin
            if (rst) begin
                chk("rst_ready", l, 32'(ready[l]), 32'd1);
                chk("rst_ack",   l, 32'(ack[l]),   32'd0);
                chk("rst_err",   l, 32'(err[l]),   32'd0);
                chk("rst_rdata", l, rdata[l],      32'd0);
                sbq[l].delete();
                free_at[l]  = 0;
                last_rd[l]  = '0;
                last_err[l] = 1'b0;
                prev_ack[l] = 1'b0;
            end else begin
                chk("ready", l, 32'(ready[l]), 32'(cyc >= free_at[l]));
                if (ack[l]) begin
                    chk("ack_consec", l, 32'(prev_ack[l]), 32'd0);
                    if (sbq[l].size() == 0) begin
                        chk("ack_spurious", l, 32'(ack[l]), 32'd0);
                    end else begin
                        t = sbq[l].pop_front();
                        chk("ack_latency", l, 32'(cyc), 32'(t.due));
                        if (is_err(t.addr)) begin
                            last_err[l] = 1'b1;
                            last_rd[l]  = '0;
                        end else begin
                            last_err[l] = 1'b0;
                            if (t.we) mem_m[l][t.addr / 4] = t.wdata;
                            else      last_rd[l] = mem_m[l][t.addr / 4];
                        end
                        exp_rd = last_rd[l];
                        chk("resp_err",   l, 32'(err[l]), 32'(last_err[l]));
                        chk("resp_rdata", l, rdata[l], exp_rd);
                    end
                end else begin
                    chk("hold_rdata", l, rdata[l], last_rd[l]);
                    chk("hold_err",   l, 32'(err[l]), 32'(last_err[l]));
                    if (sbq[l].size() > 0 && sbq[l][0].due <= cyc) begin
                        chk("ack_missing", l, 32'(ack[l]), 32'd1);
                        void'(sbq[l].pop_front());
                    end
                end
                prev_ack[l] = ack[l];
            end
        end
    end

    task automatic issue(int l, logic w, logic [31:0] a, logic [31:0] d);
        req[l] = 1'b1; we[l] = w; addr[l] = a; wdata[l] = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready[l]) begin
                @(posedge clk); #1;
                req[l] = 1'b0;
                return;
            end
        end
        chk("issue_timeout", l, 32'(ready[l]), 32'd1);
        req[l] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned kind = $urandom_range(0, 9);
        if (kind == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        if (kind == 1) return 32'(DEPTH * 4 + $urandom_range(0, 1000) * 4);
        if (kind == 2) return {$urandom_range(1, 255), 24'h0} & 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 15) * 4);
    endfunction

    task automatic rand_issue(int l, int n);
        for (int i = 0; i < n; i++) begin
            issue(l, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int l = 0; l < 2; l++) begin
            req[l] = 1'b0; we[l] = 1'b0; addr[l] = '0; wdata[l] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int l = 0; l < 2; l++)
            for (int w = 0; w < 16; w++)
                issue(l, 1'b1, 32'(w * 4), (w == 4) ? 32'h0 : $urandom);

        // Reset during WAIT aborts the store.
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        issue(0, 1'b0, 32'h10, '0);

        for (int l = 0; l < 2; l++) begin
            issue(l, 1'b1, 32'h20, 32'h1234_5678);
            issue(l, 1'b0, 32'h20, '0);
            issue(l, 1'b0, 32'h22, '0);
            issue(l, 1'b1, 32'(DEPTH * 4), 32'hCAFE_F00D);
            issue(l, 1'b0, 32'h20, '0);
            issue(l, 1'b1, 32'h0, 32'hA5A5_0001);
            issue(l, 1'b1, 32'h4, 32'h5A5A_0002);
            issue(l, 1'b0, 32'h0, '0);
            issue(l, 1'b0, 32'h4, '0);
        end

        // Request held high with changing fields; only idle-cycle requests are taken.
        for (int l = 0; l < 2; l++) begin
            req[l] = 1'b1;
            repeat (60) begin
                we[l] = 1'($urandom_range(0, 1)); addr[l] = rand_addr(); wdata[l] = $urandom;
                @(posedge clk); #1;
            end
            req[l] = 1'b0;
        end

        rand_issue(0, 80);
        rand_issue(1, 80);

        repeat (10) @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) chk("drain", l, 32'(sbq[l].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
